rom_wrapper: RTL and testbench
==============================

# rom_wrapper

AXI4 slave that fronts the off-chip boot ROM on the `ROM_*` pins of `top`. It sits on a slave port of the `AXI` interconnect, downstream of it and beside the `IM1`/`DM1` SRAM wrappers. It turns AR bursts into synchronous ROM word reads and returns them on the R channel. The ROM is read-only, so every write burst is drained and answered with SLVERR.

## Interface
Parameters:
- `ID_W`, 8, AXI slave-side ID width (`AXI_IDS_BITS`)
- `ROM_AW`, 12, ROM word-address width; ROM covers 2^ROM_AW words

Ports:
- `ACLK`  in  1  the single clock.
- `ARESETn`  in  1  reset, synchronous and active-low.
- `ARID_S`/`ARADDR_S`/`ARLEN_S`/`ARSIZE_S`/`ARBURST_S`/`ARVALID_S`  in  ID_W/32/4/3/2/1  read address channel.
- `ARREADY_S`  out  1  read address ready.
- `RID_S`/`RDATA_S`/`RRESP_S`/`RLAST_S`/`RVALID_S`  out  ID_W/32/2/1/1  read data channel.
- `RREADY_S`  in  1  read data ready.
- `AWID_S`/`AWADDR_S`/`AWLEN_S`/`AWSIZE_S`/`AWBURST_S`/`AWVALID_S`  in  ID_W/32/4/3/2/1  write address channel.
- `AWREADY_S`  out  1  write address ready.
- `WDATA_S`/`WSTRB_S`/`WLAST_S`/`WVALID_S`  in  32/4/1/1  write data channel.
- `WREADY_S`  out  1  write data ready.
- `BID_S`/`BRESP_S`/`BVALID_S`  out  ID_W/2/1  write response channel.
- `BREADY_S`  in  1  write response ready.
- `ROM_enable`  out  1  ROM chip enable.
- `ROM_read`  out  1  ROM read strobe.
- `ROM_address`  out  ROM_AW  ROM word address.
- `ROM_out`  in  32  ROM data; valid the cycle after the address is sampled.

## Operation
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_DATA.
  - R_IDLE: `ARREADY_S`=1. On the AR handshake, latch ID, LEN, BURST and word address `ARADDR_S[ROM_AW+1:2]`, clear the beat counter, then go to R_REQ.
  - R_REQ: `ROM_enable`=`ROM_read`=1 and `ROM_address`=current word address. Go to R_WAIT.
  - R_WAIT: register `ROM_out` into `RDATA_S`. Go to R_DATA.
  - R_DATA: `RVALID_S`=1. `RLAST_S`=1 when beat count equals LEN. On the R handshake:
    - if last beat, go to R_IDLE;
    - otherwise increment the beat count, advance the address (INCR and WRAP: +1 mod 2^ROM_AW; FIXED: unchanged), and go to R_REQ.
- ROM pins are 0 in every state except R_REQ. `ROM_address` holds its last value.
- `RRESP_S`=OKAY always. `RID_S` = latched ARID.
- Address handling:
  - `ARSIZE_S` is ignored; every beat is a full word.
  - `ARADDR_S[1:0]` and bits above ROM_AW+1 are ignored; addresses alias.
- Write FSM states: W_IDLE, W_DRAIN, W_RESP. It is fully independent of the read FSM.
  - W_IDLE: `AWREADY_S`=1. On the AW handshake, latch AWID and go to W_DRAIN.
  - W_DRAIN: `WREADY_S`=1; data is discarded. On a W handshake with `WLAST_S`=1, go to W_RESP.
  - W_RESP: `BVALID_S`=1, `BRESP_S`=2'b10 (SLVERR), `BID_S`=latched AWID. On the B handshake, go to W_IDLE.
- Simultaneous AR and AW in one cycle: both are accepted and the channels proceed in parallel.
- Reset: `ARESETn` low at a rising edge forces R_IDLE and W_IDLE, including mid-burst. The current burst is abandoned; no RLAST and no B response is issued for it.

## Timing
- Output values in reset and the cycle after:
  - `ARREADY_S`=1, `AWREADY_S`=1.
  - `WREADY_S`=0, `RVALID_S`=0, `RLAST_S`=0, `BVALID_S`=0.
  - `RDATA_S`=0, `RID_S`=0, `RRESP_S`=0, `BID_S`=0, `BRESP_S`=0.
  - `ROM_enable`=0, `ROM_read`=0, `ROM_address`=0.
- AR handshake in cycle T: ROM strobe in T+1, first `RVALID_S` in T+3.
- R handshake on a non-last beat in cycle k: next `RVALID_S` in k+3. A burst of N beats with `RREADY_S` always high completes 3N cycles after the AR handshake.
- Every R-channel and B-channel output is registered. `RDATA_S`, `RID_S` and `RLAST_S` are stable while `RVALID_S`=1 and `RREADY_S`=0.
- `ARREADY_S` is 0 from the cycle after the AR handshake until R_IDLE is re-entered. At most one read burst is outstanding.
- Handshake between W and B: B handshake in cycle k, `AWREADY_S`=1 again in k+1. There is no write-to-write pipelining.

## Structure
- Shared package `rom_pkg`:
  - `rd_state_t` and `wr_state_t` enums;
  - `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10;
  - `BURST_FIXED`=2'b00, `BURST_INCR`=2'b01, `BURST_WRAP`=2'b10.
- AXI widths come from the common AXI define file.
- One sub-module, `axi_wr_err_sink`, holds the write-channel drain and error responder. The DRAM wrapper reuses it for illegal-region writes.

## Test plan
- Single read: AR ID=8'h05, ADDR=0x0000_0010, LEN=0; ROM word 4 = 0xDEAD_BEEF; `RREADY_S`=1 -> `ROM_address`=4 in T+1, then in T+3 `RVALID_S`=1, `RDATA_S`=0xDEAD_BEEF, `RLAST_S`=1, `RID_S`=8'h05.
- INCR wrap: ADDR=0x0000_3FF8, LEN=3 -> `ROM_address` sequence 0xFFE, 0xFFF, 0x000, 0x001; `RLAST_S` only on beat 4.
- Backpressure: LEN=1 with `RREADY_S` held low for 5 cycles on beat 1 -> `RVALID_S` and `RDATA_S` held constant; no second ROM strobe until the handshake.
- Write reject: AW ID=8'h12, LEN=2, 3 W beats with the last flagged -> `WREADY_S` high for 3 beats; then `BVALID_S`=1, `BRESP_S`=2'b10, `BID_S`=8'h12; `ROM_enable` stays 0 throughout.
- Concurrency and reset: AR LEN=3 and AW LEN=0 issued in the same cycle -> both complete independently. Then `ARESETn`=0 for one edge during beat 2 of a new burst -> all outputs at reset values the next cycle and `ARREADY_S`=1.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared definitions for the boot-ROM AXI slave: AXI field widths, response
// and burst encodings, and the read/write channel state types.
package rom_pkg;

    // AXI field widths used on the slave port
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    // Response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Read channel states
    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_DATA
    } rd_state_t;

    // Write channel states
    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } wr_state_t;

    // INCR and WRAP both step the word address; the ROM window is a
    // power of two so WRAP degenerates to a plain modulo increment.
    function automatic logic burst_advances(input logic [1:0] burst);
        return (burst == BURST_INCR) || (burst == BURST_WRAP);
    endfunction

endpackage

// File: rtl/axi_wr_err_sink.sv
// Write-channel sink for read-only or illegal regions: accepts one AW,
// drains every W beat up to WLAST, then answers with a single SLVERR on B.
module axi_wr_err_sink
    import rom_pkg::*;
#(
    parameter int ID_W = AXI_IDS_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] aw_id,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic            w_valid,
    input  logic            w_last,
    output logic            w_ready,
    output logic [ID_W-1:0] b_id,
    output logic [1:0]      b_resp,
    output logic            b_valid,
    input  logic            b_ready
);

    wr_state_t wr_state;

    // Write FSM: IDLE accepts AW, DRAIN swallows W beats, RESP returns SLVERR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_valid && aw_ready) begin
                        b_id     <= aw_id;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        wr_state <= W_DRAIN;
                    end
                end
                W_DRAIN: begin
                    if (w_valid && w_ready && w_last) begin
                        w_ready  <= 1'b0;
                        b_valid  <= 1'b1;
                        b_resp   <= RESP_SLVERR;
                        wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_valid && b_ready) begin
                        b_valid  <= 1'b0;
                        b_resp   <= RESP_OKAY;
                        aw_ready <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    aw_ready <= 1'b1;
                    w_ready  <= 1'b0;
                    b_valid  <= 1'b0;
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/rom_wrapper.sv
// AXI4 slave in front of the synchronous boot ROM. Each read beat costs
// three cycles: strobe the ROM, capture its data, present it on R.
// Writes are drained and rejected with SLVERR by axi_wr_err_sink.
module rom_wrapper
    import rom_pkg::*;
#(
    parameter int ID_W   = AXI_IDS_BITS,
    parameter int ROM_AW = 12
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    // read address channel
    input  logic [ID_W-1:0]          ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    // read data channel
    output logic [ID_W-1:0]          RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    // write address channel
    input  logic [ID_W-1:0]          AWID_S,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
    input  logic [1:0]               AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,
    // write data channel
    input  logic [AXI_DATA_BITS-1:0] WDATA_S,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,
    // write response channel
    output logic [ID_W-1:0]          BID_S,
    output logic [1:0]               BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S,
    // ROM pins
    output logic                     ROM_enable,
    output logic                     ROM_read,
    output logic [ROM_AW-1:0]        ROM_address,
    input  logic [AXI_DATA_BITS-1:0] ROM_out
);

    rd_state_t               rd_state;
    logic [AXI_LEN_BITS-1:0] len_q;
    logic [AXI_LEN_BITS-1:0] beat_cnt;
    logic [1:0]              burst_q;
    logic                    ar_fire;
    logic                    r_fire;

    assign ar_fire = ARVALID_S && ARREADY_S;
    assign r_fire  = RVALID_S && RREADY_S;

    // The ROM never reports errors on reads
    assign RRESP_S = RESP_OKAY;

    // Beat size, byte offset, upper address bits and all write payload are
    // don't-care: every beat is a full word and the ROM window aliases.
    logic unused_inputs;
    assign unused_inputs = ^{ARADDR_S[AXI_ADDR_BITS-1:ROM_AW+2], ARADDR_S[1:0],
                             ARSIZE_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S,
                             WDATA_S, WSTRB_S};

    // Read FSM: strobe the ROM, capture the word, hold it on R until taken
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            // NOTE: data and ID registers are reset as well, since their
            // reset values are visible on the bus right after reset.
            rd_state    <= R_IDLE;
            ARREADY_S   <= 1'b1;
            RVALID_S    <= 1'b0;
            RLAST_S     <= 1'b0;
            RDATA_S     <= '0;
            RID_S       <= '0;
            len_q       <= '0;
            burst_q     <= BURST_FIXED;
            beat_cnt    <= '0;
            ROM_enable  <= 1'b0;
            ROM_read    <= 1'b0;
            ROM_address <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere here so each register
            // sees the pre-edge values of the others.
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        RID_S       <= ARID_S;
                        len_q       <= ARLEN_S;
                        burst_q     <= ARBURST_S;
                        beat_cnt    <= '0;
                        ROM_address <= ARADDR_S[ROM_AW+1:2];
                        ROM_enable  <= 1'b1;
                        ROM_read    <= 1'b1;
                        ARREADY_S   <= 1'b0;
                        rd_state    <= R_REQ;
                    end
                end
                R_REQ: begin
                    // ROM samples the address on this edge; strobe is one cycle
                    ROM_enable <= 1'b0;
                    ROM_read   <= 1'b0;
                    rd_state   <= R_WAIT;
                end
                R_WAIT: begin
                    RDATA_S  <= ROM_out;
                    RLAST_S  <= (beat_cnt == len_q);
                    RVALID_S <= 1'b1;
                    rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_fire) begin
                        RVALID_S <= 1'b0;
                        RLAST_S  <= 1'b0;
                        if (RLAST_S) begin
                            ARREADY_S <= 1'b1;
                            rd_state  <= R_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + AXI_LEN_BITS'(1);
                            if (burst_advances(burst_q)) begin
                                ROM_address <= ROM_address + ROM_AW'(1);
                            end
                            ROM_enable <= 1'b1;
                            ROM_read   <= 1'b1;
                            rd_state   <= R_REQ;
                        end
                    end
                end
                default: begin
                    ARREADY_S  <= 1'b1;
                    RVALID_S   <= 1'b0;
                    RLAST_S    <= 1'b0;
                    ROM_enable <= 1'b0;
                    ROM_read   <= 1'b0;
                    rd_state   <= R_IDLE;
                end
            endcase
        end
    end

    // Write side: independent drain-and-reject responder
    axi_wr_err_sink #(
        .ID_W(ID_W)
    ) u_wr_sink (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .aw_id    (AWID_S),
        .aw_valid (AWVALID_S),
        .aw_ready (AWREADY_S),
        .w_valid  (WVALID_S),
        .w_last   (WLAST_S),
        .w_ready  (WREADY_S),
        .b_id     (BID_S),
        .b_resp   (BRESP_S),
        .b_valid  (BVALID_S),
        .b_ready  (BREADY_S)
    );

endmodule

// File: tb/tb_rom_wrapper.sv
// Self-checking bench for rom_wrapper: behavioural ROM, a negedge monitor
// that predicts every channel from the AXI rules, and directed scenarios
// with hand-computed expectations.
module tb_rom_wrapper;
    import rom_pkg::*;

    localparam int ID_W      = 8;
    localparam int ROM_AW    = 12;
    localparam int ROM_WORDS = 1 << ROM_AW;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [ID_W-1:0]   ARID_S = '0;
    logic [31:0]       ARADDR_S = '0;
    logic [3:0]        ARLEN_S = '0;
    logic [2:0]        ARSIZE_S = 3'd2;
    logic [1:0]        ARBURST_S = BURST_INCR;
    logic              ARVALID_S = 1'b0;
    logic              ARREADY_S;
    logic [ID_W-1:0]   RID_S;
    logic [31:0]       RDATA_S;
    logic [1:0]        RRESP_S;
    logic              RLAST_S;
    logic              RVALID_S;
    logic              RREADY_S = 1'b1;
    logic [ID_W-1:0]   AWID_S = '0;
    logic [31:0]       AWADDR_S = '0;
    logic [3:0]        AWLEN_S = '0;
    logic [2:0]        AWSIZE_S = 3'd2;
    logic [1:0]        AWBURST_S = BURST_INCR;
    logic              AWVALID_S = 1'b0;
    logic              AWREADY_S;
    logic [31:0]       WDATA_S = '0;
    logic [3:0]        WSTRB_S = 4'hF;
    logic              WLAST_S = 1'b0;
    logic              WVALID_S = 1'b0;
    logic              WREADY_S;
    logic [ID_W-1:0]   BID_S;
    logic [1:0]        BRESP_S;
    logic              BVALID_S;
    logic              BREADY_S = 1'b1;
    logic              ROM_enable;
    logic              ROM_read;
    logic [ROM_AW-1:0] ROM_address;
    logic [31:0]       ROM_out = '0;

    rom_wrapper #(.ID_W(ID_W), .ROM_AW(ROM_AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ROM_enable(ROM_enable), .ROM_read(ROM_read), .ROM_address(ROM_address),
        .ROM_out(ROM_out)
    );

    always #5 ACLK = ~ACLK;

    // Synchronous ROM: data appears the cycle after the address is sampled
    logic [31:0] rom_mem [ROM_WORDS];
    always @(posedge ACLK) if (ROM_enable && ROM_read) ROM_out <= rom_mem[ROM_address];

    function automatic logic [31:0] rom_word(input int a);
        return 32'h5A00_0000 ^ (32'(a) << 12) ^ 32'(a * 7);
    endfunction

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model + per-cycle compare
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    beat_t             r_exp[$];
    logic [ROM_AW-1:0] a_exp[$];
    logic              strobe_credit = 1'b0;
    int                due = 0;
    logic              rv_pending = 1'b0;
    logic              aw_busy = 1'b0;
    logic              w_open = 1'b0;
    logic              b_pending = 1'b0;
    logic [ID_W-1:0]   exp_bid = '0;
    int                r_done = 0;
    int                b_done = 0;
    int                w_beats = 0;
    int                rom_strobes = 0;
    beat_t             e;
    logic [ROM_AW-1:0] base;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            r_exp.delete();
            a_exp.delete();
            strobe_credit = 1'b0;
            rv_pending = 1'b0;
            aw_busy = 1'b0;
            w_open = 1'b0;
            b_pending = 1'b0;
        end else begin
            // read address: one burst at a time
            check("arready", ARREADY_S, r_exp.size() == 0);
            if (ARVALID_S && ARREADY_S) begin
                base = ARADDR_S[ROM_AW+1:2];
                for (int i = 0; i <= int'(ARLEN_S); i++) begin
                    logic [ROM_AW-1:0] wa;
                    wa = (ARBURST_S == BURST_FIXED) ? base : ROM_AW'(int'(base) + i);
                    a_exp.push_back(wa);
                    r_exp.push_back('{data: rom_mem[wa], id: ARID_S, last: (i == int'(ARLEN_S))});
                end
                strobe_credit = 1'b1;
                due = cyc + 3;
            end
            // ROM pins
            check("rom_read_eq_enable", ROM_read, ROM_enable);
            if (ROM_enable) begin
                rom_strobes++;
                check("rom_strobe_allowed", strobe_credit, 1'b1);
                check("rom_strobe_queued", a_exp.size() > 0, 1'b1);
                if (a_exp.size() > 0) check("rom_address", ROM_address, a_exp.pop_front());
                strobe_credit = 1'b0;
            end
            // read data
            if (RVALID_S) begin
                if (!rv_pending) check("rvalid_latency", cyc, due);
                check("rvalid_expected", r_exp.size() > 0, 1'b1);
                if (r_exp.size() > 0) begin
                    e = r_exp[0];
                    check("rdata", RDATA_S, e.data);
                    check("rid", RID_S, e.id);
                    check("rlast", RLAST_S, e.last);
                    check("rresp", RRESP_S, RESP_OKAY);
                    if (RREADY_S) begin
                        void'(r_exp.pop_front());
                        r_done++;
                        if (!e.last) begin
                            strobe_credit = 1'b1;
                            due = cyc + 3;
                        end
                    end
                end
            end
            rv_pending = RVALID_S && !RREADY_S;
            // write side
            check("awready", AWREADY_S, !aw_busy);
            check("wready", WREADY_S, w_open);
            check("bvalid", BVALID_S, b_pending);
            if (BVALID_S) begin
                check("bresp", BRESP_S, RESP_SLVERR);
                check("bid", BID_S, exp_bid);
            end
            if (AWVALID_S && AWREADY_S) begin
                aw_busy = 1'b1;
                w_open = 1'b1;
                exp_bid = AWID_S;
            end
            if (WVALID_S && WREADY_S && w_open) begin
                w_beats++;
                if (WLAST_S) begin
                    w_open = 1'b0;
                    b_pending = 1'b1;
                end
            end
            if (BVALID_S && BREADY_S && b_pending) begin
                b_pending = 1'b0;
                aw_busy = 1'b0;
                b_done++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int                t_acc;
    logic [ROM_AW-1:0] col_addr [16];
    int                col_n, col_beats, col_rlasts, col_last_beat, col_end;
    logic [31:0]       col_data;

    task automatic drive_ar(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size);
        @(posedge ACLK); #1;
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARBURST_S = burst;
        ARSIZE_S = size; ARVALID_S = 1'b1;
    endtask

    task automatic wait_ar_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK);
            if (ARREADY_S) begin ok = 1'b1; t_acc = cyc; break; end
        end
        check("ar_accept", ok, 1'b1);
        @(posedge ACLK); #1;
        ARVALID_S = 1'b0;
    endtask

    task automatic collect_burst(input int budget);
        logic done = 1'b0;
        col_n = 0; col_beats = 0; col_rlasts = 0; col_last_beat = 0; col_end = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (ROM_enable && col_n < 16) begin col_addr[col_n] = ROM_address; col_n++; end
            if (RVALID_S && RREADY_S) begin
                col_beats++;
                col_data = RDATA_S;
                if (RLAST_S) begin
                    col_rlasts++; col_last_beat = col_beats; col_end = cyc;
                    done = 1'b1; break;
                end
            end
        end
        check("burst_done", done, 1'b1);
    endtask

    task automatic send_w(input int n);
        int cnt = 0;
        logic ok = 1'b0;
        WVALID_S = 1'b1;
        WLAST_S = (n == 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK);
            if (WREADY_S) begin
                cnt++;
                @(posedge ACLK); #1;
                if (cnt == n) begin WVALID_S = 1'b0; WLAST_S = 1'b0; ok = 1'b1; break; end
                WDATA_S = WDATA_S + 32'h11;
                WLAST_S = (cnt == n - 1);
            end
        end
        check("w_drained", ok, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (ARREADY_S && AWREADY_S && !RVALID_S && !BVALID_S && !WREADY_S && !ARVALID_S) begin
                ok = 1'b1; break;
            end
        end
        check("idle_reached", ok, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, ARREADY_S, 1'b1);
        check({tag, "_awready"}, AWREADY_S, 1'b1);
        check({tag, "_wready"}, WREADY_S, 1'b0);
        check({tag, "_rvalid"}, RVALID_S, 1'b0);
        check({tag, "_rlast"}, RLAST_S, 1'b0);
        check({tag, "_bvalid"}, BVALID_S, 1'b0);
        check({tag, "_rdata"}, RDATA_S, 32'h0);
        check({tag, "_rid"}, RID_S, 8'h00);
        check({tag, "_rresp"}, RRESP_S, 2'b00);
        check({tag, "_bid"}, BID_S, 8'h00);
        check({tag, "_bresp"}, BRESP_S, 2'b00);
        check({tag, "_rom_en"}, ROM_enable, 1'b0);
        check({tag, "_rom_rd"}, ROM_read, 1'b0);
        check({tag, "_rom_addr"}, ROM_address, 12'h000);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        logic [ROM_AW-1:0] exp_wrap [4];
        logic [31:0] held;
        logic ok;
        int rd0, bd0, wb0, rs0;

        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = rom_word(i);
        rom_mem[4] = 32'hDEAD_BEEF;
        exp_wrap = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

        // reset and the cycle after
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("in_reset");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("after_reset");

        // single read of word 4
        drive_ar(8'h05, 32'h0000_0010, 4'd0, BURST_INCR, 3'd2);
        wait_ar_accept();
        @(negedge ACLK);
        check("single_strobe_t1", ROM_enable, 1'b1);
        check("single_addr_t1", ROM_address, 12'h004);
        @(negedge ACLK);
        check("single_rvalid_t2", RVALID_S, 1'b0);
        @(negedge ACLK);
        check("single_rvalid_t3", RVALID_S, 1'b1);
        check("single_rdata_t3", RDATA_S, 32'hDEAD_BEEF);
        check("single_rlast_t3", RLAST_S, 1'b1);
        check("single_rid_t3", RID_S, 8'h05);
        wait_idle(20);

        // INCR burst wrapping past the top of the ROM window
        drive_ar(8'h21, 32'h0000_3FF8, 4'd3, BURST_INCR, 3'd2);
        wait_ar_accept();
        collect_burst(60);
        check("wrap_strobes", col_n, 4);
        for (int i = 0; i < 4; i++) check("wrap_addr_seq", col_addr[i], exp_wrap[i]);
        check("wrap_rlast_count", col_rlasts, 1);
        check("wrap_rlast_beat", col_last_beat, 4);
        check("wrap_duration", col_end - t_acc, 12);
        wait_idle(20);

        // FIXED burst: same word every beat
        drive_ar(8'h44, 32'h0000_0020, 4'd2, BURST_FIXED, 3'd2);
        wait_ar_accept();
        collect_burst(60);
        check("fixed_strobes", col_n, 3);
        for (int i = 0; i < 3; i++) check("fixed_addr", col_addr[i], 12'h008);
        wait_idle(20);

        // aliased address, byte offset and size ignored -> word 4
        drive_ar(8'h06, 32'hFFFF_4013, 4'd0, BURST_INCR, 3'd0);
        wait_ar_accept();
        collect_burst(30);
        check("alias_addr", col_addr[0], 12'h004);
        check("alias_data", col_data, 32'hDEAD_BEEF);
        wait_idle(20);

        // backpressure on beat 1 of a 2-beat burst
        RREADY_S = 1'b0;
        rs0 = rom_strobes;
        drive_ar(8'h33, 32'h0000_0100, 4'd1, BURST_INCR, 3'd2);
        wait_ar_accept();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (RVALID_S) begin ok = 1'b1; break; end
        end
        check("bp_rvalid_seen", ok, 1'b1);
        held = RDATA_S;
        check("bp_data", held, rom_word(64));
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_rvalid_hold", RVALID_S, 1'b1);
            check("bp_rdata_hold", RDATA_S, held);
            check("bp_no_strobe", ROM_enable, 1'b0);
        end
        #2;
        check("bp_strobe_count", rom_strobes - rs0, 1);
        @(posedge ACLK); #1;
        RREADY_S = 1'b1;
        wait_idle(30);

        // write reject
        BREADY_S = 1'b0;
        rs0 = rom_strobes; wb0 = w_beats;
        @(posedge ACLK); #1;
        AWID_S = 8'h12; AWLEN_S = 4'd2; AWADDR_S = 32'h0000_0040; AWVALID_S = 1'b1;
        WDATA_S = 32'h1234_5678;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (AWREADY_S) begin ok = 1'b1; break; end
        end
        check("aw_accept", ok, 1'b1);
        @(posedge ACLK); #1;
        AWVALID_S = 1'b0;
        send_w(3);
        #2;
        check("w_beats", w_beats - wb0, 3);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (BVALID_S) begin ok = 1'b1; break; end
        end
        check("b_seen", ok, 1'b1);
        check("b_resp", BRESP_S, 2'b10);
        check("b_id", BID_S, 8'h12);
        @(negedge ACLK);
        check("b_hold", BVALID_S, 1'b1);
        @(posedge ACLK); #1;
        BREADY_S = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("awready_after_b", AWREADY_S, 1'b1);
        check("bvalid_after_b", BVALID_S, 1'b0);
        check("write_no_rom", rom_strobes - rs0, 0);

        // concurrent AR and AW in the same cycle
        rd0 = r_done; bd0 = b_done;
        @(posedge ACLK); #1;
        ARID_S = 8'h51; ARADDR_S = 32'h0000_0200; ARLEN_S = 4'd3; ARBURST_S = BURST_WRAP;
        ARVALID_S = 1'b1;
        AWID_S = 8'h62; AWLEN_S = 4'd0; AWVALID_S = 1'b1;
        @(negedge ACLK);
        check("both_ready", {ARREADY_S, AWREADY_S}, 2'b11);
        @(posedge ACLK); #1;
        ARVALID_S = 1'b0; AWVALID_S = 1'b0;
        send_w(1);
        wait_idle(60);
        #2;
        check("conc_r_beats", r_done - rd0, 4);
        check("conc_b_resp", b_done - bd0, 1);

        // reset during beat 2 of a burst
        drive_ar(8'h77, 32'h0000_0400, 4'd3, BURST_INCR, 3'd2);
        wait_ar_accept();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (RVALID_S && RREADY_S) begin ok = 1'b1; break; end
        end
        check("rst_first_beat", ok, 1'b1);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("mid_burst_reset");
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check("post_reset_quiet", RVALID_S, 1'b0);
        end

        // recovery read
        drive_ar(8'h05, 32'h0000_0010, 4'd0, BURST_INCR, 3'd2);
        wait_ar_accept();
        collect_burst(30);
        check("recover_data", col_data, 32'hDEAD_BEEF);
        wait_idle(20);

        repeat (2) @(negedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
